// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp codes, phase type and fault codes shared by the conflict monitor.
package traffic_pkg;
  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

  localparam logic [2:0] F_NONE       = 3'd0;
  localparam logic [2:0] F_CONFLICT   = 3'd1;
  localparam logic [2:0] F_INVALID    = 3'd2;
  localparam logic [2:0] F_TRANSITION = 3'd3;
  localparam logic [2:0] F_SHORT      = 3'd4;
  localparam logic [2:0] F_STUCK      = 3'd5;
endpackage

// File: rtl/traffic_phase_decoder.sv
// traffic_phase_decoder: maps a {main, cross} lamp pair to a phase plus valid/conflict flags.
module traffic_phase_decoder
  import traffic_pkg::*;
(
  input  logic [2:0] main_i,
  input  logic [2:0] cross_i,
  output logic [1:0] phase_o,
  output logic       valid_o,
  output logic       conflict_o
);
  logic [5:0] pair;
  assign pair = {main_i, cross_i};
  assign valid_o = pair inside {{LAMP_GREEN, LAMP_RED}, {LAMP_YELLOW, LAMP_RED},
                                {LAMP_RED, LAMP_GREEN}, {LAMP_RED, LAMP_YELLOW}};
  assign phase_o = pair == {LAMP_YELLOW, LAMP_RED}   ? P1 :
                   pair == {LAMP_RED, LAMP_GREEN}    ? P2 :
                   pair == {LAMP_RED, LAMP_YELLOW}   ? P3 : P0;
  // Both directions showing a go/caution aspect at once.
  assign conflict_o = main_i inside {LAMP_GREEN, LAMP_YELLOW} && cross_i inside {LAMP_GREEN, LAMP_YELLOW};
endmodule

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: checks controller lamp codes for conflicts, order and dwell faults,
// latches the first fault and forces all-way flashing red while latched.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MAIN_GREEN_MIN  = 16,
  parameter int CROSS_GREEN_MIN = 10,
  parameter int YELLOW_LEN      = 3,
  parameter int MAX_DWELL       = 20,
  parameter int WARMUP          = 2
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic [2:0] main_st,
  input  logic [2:0] cross_st,
  input  logic       fault_clear,
  output logic [2:0] main_lamp,
  output logic [2:0] cross_lamp,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] phase,
  output logic [7:0] cycle_count,
  output logic [7:0] fault_count
);
  logic [1:0] dec_phase;
  logic       dec_valid, dec_conflict;
  phase_t     phase_q, phase_d;
  logic [5:0] dwell_q, dwell_d, dwell_inc;
  logic [7:0] warm_q, warm_d, ccnt_q, ccnt_d, fcnt_q, fcnt_d;
  logic [2:0] code_q, code_d, viol, main_lamp_q, main_lamp_d, cross_lamp_q, cross_lamp_d;
  logic       sync_q, sync_d, fault_q, fault_d, blink_q, blink_d;
  logic       active, track, same, succ, dwell_ok, entry, cleared, wrap;

  traffic_phase_decoder u_dec (
    .main_i(main_st),
    .cross_i(cross_st),
    .phase_o(dec_phase),
    .valid_o(dec_valid),
    .conflict_o(dec_conflict)
  );

  assign active    = warm_q == 8'd0;
  assign track     = active && dec_valid;
  assign same      = dec_phase == phase_q;
  assign succ      = dec_phase == 2'(phase_q + 2'd1);
  assign dwell_inc = dwell_q == 6'd63 ? 6'd63 : dwell_q + 6'd1;
  assign dwell_ok  = phase_q == P0 ? dwell_q >= 6'(MAIN_GREEN_MIN) :
                     phase_q == P2 ? dwell_q >= 6'(CROSS_GREEN_MIN) : dwell_q == 6'(YELLOW_LEN);
  // Until the first valid sample after warm-up is accepted, no order or dwell history exists.
  assign viol = !active      ? F_NONE :
                dec_conflict ? F_CONFLICT :
                !dec_valid   ? F_INVALID :
                !sync_q      ? F_NONE :
                same         ? (dwell_inc == 6'(MAX_DWELL + 1) ? F_STUCK : F_NONE) :
                !succ        ? F_TRANSITION :
                !dwell_ok    ? F_SHORT : F_NONE;
  assign entry   = viol != F_NONE && (!fault_q || fault_clear);
  assign cleared = fault_clear && viol == F_NONE;
  assign wrap    = track && sync_q && phase_q == P3 && dec_phase == P0;

  always_comb begin
    phase_d      = track ? phase_t'(dec_phase) : phase_q;
    dwell_d      = !track ? dwell_q : (sync_q && same) ? dwell_inc : 6'd1;
    sync_d       = !cleared && (sync_q || track);
    warm_d       = cleared ? 8'(WARMUP) : active ? warm_q : warm_q - 8'd1;
    ccnt_d       = ccnt_q + {7'd0, wrap};
    fault_d      = entry || (fault_q && !cleared);
    code_d       = entry ? viol : cleared ? F_NONE : code_q;
    fcnt_d       = fcnt_q + {7'd0, entry && fcnt_q != 8'hff};
    blink_d      = entry || (fault_q && !cleared && !blink_q);
    main_lamp_d  = fault_d ? (blink_d ? LAMP_RED : LAMP_OFF) : main_st;
    cross_lamp_d = fault_d ? (blink_d ? LAMP_RED : LAMP_OFF) : cross_st;
  end

  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      phase_q      <= P0;
      dwell_q      <= 6'd0;
      warm_q       <= 8'(WARMUP);
      sync_q       <= 1'b0;
      ccnt_q       <= 8'd0;
      fault_q      <= 1'b0;
      code_q       <= F_NONE;
      fcnt_q       <= 8'd0;
      blink_q      <= 1'b0;
      main_lamp_q  <= LAMP_RED;
      cross_lamp_q <= LAMP_RED;
    end else begin
      phase_q      <= phase_d;
      dwell_q      <= dwell_d;
      warm_q       <= warm_d;
      sync_q       <= sync_d;
      ccnt_q       <= ccnt_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
      fcnt_q       <= fcnt_d;
      blink_q      <= blink_d;
      main_lamp_q  <= main_lamp_d;
      cross_lamp_q <= cross_lamp_d;
    end
  end

  assign main_lamp   = main_lamp_q;
  assign cross_lamp  = cross_lamp_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign phase       = phase_q;
  assign cycle_count = ccnt_q;
  assign fault_count = fcnt_q;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: directed plus random lamp sequences against a rule-level reference model.
module tb_traffic_conflict_monitor;
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100;
  logic clk_1Hz = 0, reset = 1, fault_clear = 0;
  logic [2:0] main_st = 0, cross_st = 0, main_lamp, cross_lamp, fault_code;
  logic fault;
  logic [1:0] phase;
  logic [7:0] cycle_count, fault_count;
  int tests = 0, fails = 0;
  logic [2:0] pm [4] = '{G, Y, R, R};
  logic [2:0] pc [4] = '{R, R, G, Y};
  int nom [4] = '{16, 3, 10, 3};
  int m_ph, m_dw, m_warm, m_fault, m_code, m_fcnt, m_ccnt, m_blink, m_ml, m_cl, m_sync;

  traffic_conflict_monitor dut (
    .clk_1Hz(clk_1Hz), .reset(reset), .main_st(main_st), .cross_st(cross_st),
    .fault_clear(fault_clear), .main_lamp(main_lamp), .cross_lamp(cross_lamp),
    .fault(fault), .fault_code(fault_code), .phase(phase),
    .cycle_count(cycle_count), .fault_count(fault_count)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns phase 0..3, -2 for a conflict, -1 for any other illegal pair.
  function automatic int decode(input logic [2:0] m, input logic [2:0] c);
    for (int i = 0; i < 4; i++) if (m == pm[i] && c == pc[i]) return i;
    if ((m == G || m == Y) && (c == G || c == Y)) return -2;
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_dw = 0; m_warm = 2; m_sync = 0; m_fault = 0; m_code = 0;
    m_fcnt = 0; m_ccnt = 0; m_blink = 0; m_ml = 4; m_cl = 4;
  endtask

  task automatic model_edge(input logic [2:0] m, input logic [2:0] c, input logic clr);
    int p, v, need;
    p = decode(m, c);
    v = 0;
    if (m_warm > 0) m_warm--;
    else if (p == -2) v = 1;
    else if (p == -1) v = 2;
    else if (m_sync == 0) begin m_ph = p; m_dw = 1; m_sync = 1; end
    else if (p == m_ph) begin
      m_dw = m_dw < 63 ? m_dw + 1 : 63;
      if (m_dw == 21) v = 5;
    end else begin
      if (p != (m_ph + 1) % 4) v = 3;
      else begin
        need = (m_ph == 0) ? (m_dw >= 16) : (m_ph == 2) ? (m_dw >= 10) : (m_dw == 3);
        if (!need) v = 4;
        if (m_ph == 3) m_ccnt = (m_ccnt + 1) % 256;
      end
      m_ph = p; m_dw = 1;
    end
    if (v != 0 && (m_fault == 0 || clr)) begin
      m_fault = 1; m_code = v; m_blink = 1;
      if (m_fcnt < 255) m_fcnt++;
    end else if (clr && v == 0) begin
      m_fault = 0; m_code = 0; m_warm = 2; m_sync = 0; m_blink = 0;
    end else if (m_fault == 1) m_blink = 1 - m_blink;
    m_ml = m_fault ? (m_blink ? 4 : 0) : int'(m);
    m_cl = m_fault ? (m_blink ? 4 : 0) : int'(c);
  endtask

  task automatic check_all();
    check("main_lamp", main_lamp, m_ml);
    check("cross_lamp", cross_lamp, m_cl);
    check("fault", fault, m_fault);
    check("fault_code", fault_code, m_code);
    check("phase", phase, m_ph);
    check("cycle_count", cycle_count, m_ccnt);
    check("fault_count", fault_count, m_fcnt);
  endtask

  task automatic step(input logic [2:0] m, input logic [2:0] c, input logic clr);
    main_st = m; cross_st = c; fault_clear = clr;
    @(posedge clk_1Hz);
    model_edge(m, c, clr);
    #1;
    check_all();
  endtask

  task automatic run(input int p, input int n);
    repeat (n) step(pm[p], pc[p], 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_main"}, main_lamp, 4);
    check({tag, "_cross"}, cross_lamp, 4);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_code"}, fault_code, 0);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_ccnt"}, cycle_count, 0);
    check({tag, "_fcnt"}, fault_count, 0);
  endtask

  initial begin
    int cur, len;
    logic clr;
    model_reset();
    #12;
    check_reset_values("reset");
    @(posedge clk_1Hz); #1 reset = 0;
    step(3'b000, 3'b000, 0); step(3'b000, 3'b000, 0);
    repeat (3) begin run(0, 16); run(1, 3); run(2, 10); run(3, 3); end
    run(0, 1);
    check("nominal_ccnt", cycle_count, 3);
    check("nominal_fault", fault, 0);
    run(0, 4);
    step(G, G, 0);
    check("conflict_code", fault_code, 1);
    check("conflict_first_red", main_lamp, 4);
    run(0, 1);
    check("flash_off", cross_lamp, 0);
    run(0, 2);
    step(G, R, 1);
    check("clear_fault", fault, 0);
    step(3'b000, 3'b000, 0); step(3'b000, 3'b000, 0);
    run(2, 10); run(3, 3); run(0, 16); run(1, 2); run(2, 1);
    check("short_yellow_code", fault_code, 4);
    step(3'b011, R, 1);
    check("contention_fault", fault, 1);
    check("contention_code", fault_code, 2);
    check("contention_fcnt", fault_count, 3);
    run(2, 0);
    step(R, G, 1);
    step(3'b000, 3'b000, 0); step(3'b000, 3'b000, 0);
    run(0, 16); run(2, 1);
    check("skip_code", fault_code, 3);
    step(R, G, 1);
    step(3'b000, 3'b000, 0); step(3'b000, 3'b000, 0);
    run(2, 20);
    check("stuck_pre", fault, 0);
    run(2, 1);
    check("stuck_code", fault_code, 5);
    step(R, G, 1);
    cur = 0;
    repeat (60) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 22)) : nom[cur];
      for (int k = 0; k < len; k++) begin
        clr = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 39) == 0) step(3'($urandom), 3'($urandom), clr);
        else step(pm[cur], pc[cur], clr);
      end
      cur = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : (cur + 1) % 4;
    end
    repeat (300) step(G, G, 1);
    check("sat_fcnt", fault_count, 255);
    #2 reset = 1;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(posedge clk_1Hz); #1 reset = 0;
    step(3'b000, 3'b000, 0); step(3'b000, 3'b000, 0);
    run(0, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Independent safety monitor on the receiving end of the traffic controller's lamp outputs. It decodes the main and cross 3-bit lamp codes each 1 Hz tick, checks for conflicts, illegal codes, illegal phase order and dwell-time violations, and latches a sticky fault. While a fault is latched it drives the lamp pins with all-way flashing red. It sits between the controller's PMOD_B/PMOD_C outputs and the physical lamp drivers.

## Interface
- MAIN_GREEN_MIN, 16: minimum cycles in phase P0 (main green).
- CROSS_GREEN_MIN, 10: minimum cycles in phase P2 (cross green).
- YELLOW_LEN, 3: exact cycles required in P1 and P3.
- MAX_DWELL, 20: maximum cycles in any phase before a stuck fault.
- WARMUP, 2: cycles after reset or clear during which checks are suppressed.

Ports:
- clk_1Hz  in  1  system tick; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- main_st  in  3  main lamp code: 001 green, 010 yellow, 100 red.
- cross_st  in  3  cross lamp code, same encoding.
- fault_clear  in  1  synchronous request to clear a latched fault.
- main_lamp  out  3  lamp driver output, main.
- cross_lamp  out  3  lamp driver output, cross.
- fault  out  1  sticky fault flag.
- fault_code  out  3  code of the first fault since the last clear.
- phase  out  2  last accepted phase, P0–P3.
- cycle_count  out  8  completed P3→P0 transitions; wraps at 255→0.
- fault_count  out  8  fault entries; saturates at 255.

## Operation
- Phase decode, as {main,cross}:
  - 001/100 = P0; 010/100 = P1; 100/001 = P2; 100/010 = P3.
  - Any other pair is either a conflict or invalid.
- Fault codes, in priority order (highest first):
  - 1 = conflict: neither input is 100, and both are legal codes.
  - 2 = invalid: any pair other than the four phases and not a conflict.
  - 3 = illegal transition: new phase is not the same phase or the successor mod 4.
  - 4 = short dwell, checked on the phase change. The previous phase's dwell must be ≥ MAIN_GREEN_MIN for P0, ≥ CROSS_GREEN_MIN for P2, and == YELLOW_LEN for P1/P3.
  - 5 = stuck: dwell reaches MAX_DWELL+1 within one phase.
- Dwell counter:
  - 6-bit, saturating at 63.
  - Loads 1 on the first sample of a new phase; otherwise increments.
- Warm-up:
  - A counter suppresses all checks for WARMUP cycles after reset or a successful clear.
  - The first valid sample after warm-up is accepted as any phase, with dwell = 1, and no transition or dwell check applies to it.
  - Codes 1/2 during warm-up are ignored; phase and dwell do not update on such samples.
- Fault latch:
  - fault, fault_code and fault_count update on the edge that samples the violation.
  - Later violations while fault=1 do not change fault_code.
- Clear:
  - fault_clear=1 at an edge with no violation on that edge's sample sets fault=0 and fault_code=0, and restarts warm-up.
  - If a violation is present on the same edge, the violation wins: fault stays 1, fault_code takes the new code, and fault_count increments.
- Lamp outputs:
  - fault=0: main_lamp/cross_lamp are the inputs registered with 1-cycle latency.
  - fault=1: a blink register toggles every cycle. It is forced to 1 on the fault-entry edge. Both lamps = blink ? 100 : 000.
- cycle_count increments on an accepted P3→P0 transition, whether or not it carries a dwell fault.

## Timing
- Reset values:
  - main_lamp = cross_lamp = 100 (all red).
  - fault = 0; fault_code = 0; phase = 0; cycle_count = 0; fault_count = 0.
  - Internal: dwell = 0, warm-up counter = WARMUP, blink = 0.
- Inputs are sampled at rising edge N. Any fault, and the first flash-red output, are visible after edge N.
- Pass-through latency is 1 cycle.
- Reset mid-fault clears the latch immediately (asynchronous) and restarts warm-up.
- A nominal controller cycle (16/3/10/3 cycles) must never fault. With no faults, cycle_count increments once per 32 cycles.

## Structure
- Shared package traffic_pkg holds:
  - lamp codes LAMP_GREEN, LAMP_YELLOW, LAMP_RED;
  - the phase typedef P0–P3;
  - the fault-code constants.
- Sub-module traffic_phase_decoder: combinational. Maps {main_st, cross_st} to phase, valid and conflict.
- The top holds dwell, warm-up, latch, blink and counters.

## Test plan
- Nominal: drive 16/3/10/3 cycles ×3 → fault stays 0, cycle_count = 3, lamps equal the inputs delayed 1 cycle.
- Conflict: main=001, cross=001 mid-P0 → fault=1 and fault_code=1 after that edge; lamps alternate 100/000 starting with 100.
- Short yellow: P1 held 2 cycles, then P2 → fault_code=4 on the P2 sample edge.
- Skip/stuck: P0→P2 gives fault_code=3. Separately, P2 held 21 cycles gives fault_code=5 on the 21st sample.
- Clear contention:
  - fault_clear with a valid input → fault=0; warm-up of 2 cycles, then resync at any phase.
  - fault_clear with input 011/100 → fault stays 1, fault_code=2, fault_count increments.
- Async reset during flashing → outputs return to reset values without a clock edge; 8-bit fault_count saturates at 255 after 300 forced faults.
